// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the single-pixel convolution engine: kicks the engine once per output
// pixel, collects each result into a linear-address buffer, with abort-drain and timeout.
module conv_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_SIZE   = 5,
  parameter int unsigned TIMEOUT    = 32,
  localparam int unsigned NPIX      = IMG_SIZE * IMG_SIZE,
  localparam int unsigned AW        = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int unsigned TW        = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic                    err_o,
  output logic [7:0]              frame_cnt_o,
  output logic                    eng_start_o,
  input  logic                    eng_valid_i,
  input  logic [2*DATA_WIDTH-1:0] eng_data_i,
  output logic                    wr_en_o,
  output logic [AW-1:0]           wr_addr_o,
  output logic [2*DATA_WIDTH-1:0] wr_data_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StKick = 3'd1;
  localparam logic [2:0] StClr  = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [AW-1:0]           pix_q, pix_d;
  logic                    drain_q, drain_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    err_q, err_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    eng_start_q, eng_start_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [2*DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    drain_d     = drain_q;
    tcnt_d      = tcnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    eng_start_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    // Abort only drains: the engine tracks its own position and must finish the frame.
    if (state_q != StIdle && abort_i) begin
      drain_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d       = 1'b0;
          pix_d       = '0;
          drain_d     = 1'b0;
          tcnt_d      = '0;
          busy_d      = 1'b1;
          eng_start_d = 1'b1;
          state_d     = StKick;
        end
      end
      StKick: begin
        state_d = StClr;
      end
      StClr, StWait: begin
        if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          tcnt_d  = '0;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (state_q == StClr) begin
            if (!eng_valid_i) begin
              state_d = StWait;
            end
          end else if (eng_valid_i) begin
            wr_data_d = eng_data_i;
            wr_addr_d = pix_q;
            wr_en_d   = !drain_d;
            if (pix_q == AW'(NPIX - 1)) begin
              done_d    = !drain_d;
              aborted_d = drain_d;
              if (!drain_d) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
              end
              state_d = StDone;
            end else begin
              pix_d       = pix_q + AW'(1);
              tcnt_d      = '0;
              eng_start_d = 1'b1;
              state_d     = StKick;
            end
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pix_q       <= '0;
      drain_q     <= 1'b0;
      tcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      eng_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      drain_q     <= drain_d;
      tcnt_q      <= tcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      eng_start_q <= eng_start_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign eng_start_o = eng_start_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: behavioural engine with random latency/data plus a frame-level
// reference (address p gets the p-th value the engine produced; aborted frames stop writing).
module tb_conv_frame_ctrl;
  localparam int DW = 8;
  localparam int IS = 5;
  localparam int NP = IS * IS;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, aborted, err, eng_start, wr_en;
  logic [7:0]  frame_cnt;
  logic        ev;
  logic [15:0] edata;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  conv_frame_ctrl #(.DATA_WIDTH(DW), .IMG_SIZE(IS), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .err_o(err),
    .frame_cnt_o(frame_cnt), .eng_start_o(eng_start), .eng_valid_i(ev),
    .eng_data_i(edata), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: clears valid on trigger, raises it after a latency with the next value.
  int          ecnt = 0;
  int          eidx = 0;
  int          mute_pix = -1;
  int          fixed_lat = 11;
  bit          rnd_data = 1'b0;
  logic [15:0] nd;
  logic [15:0] vals[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev <= 1'b0; ecnt <= 0; eidx <= 0; edata <= '0;
    end else if (eng_start) begin
      ev <= 1'b0;
      if (eidx == mute_pix) ecnt <= 0;
      else ecnt <= ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 20))) - 1;
      nd = rnd_data ? 16'($urandom) : 16'(100 + eidx);
      edata <= nd;
      vals.push_back(nd);
      eidx <= (eidx == NP - 1) ? 0 : eidx + 1;
    end else if (ecnt == 1) begin
      ev <= 1'b1; ecnt <= 0;
    end else if (ecnt > 1) begin
      ecnt <= ecnt - 1;
    end
  end

  // Monitor
  logic [31:0] waddr[$];
  logic [31:0] wdata[$];
  int n_kick, n_done, n_abort, n_both, viol;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin waddr.push_back(32'(wr_addr)); wdata.push_back(32'(wr_data)); end
      if (eng_start) begin n_kick++; if (ecnt != 0) viol++; end
      if (done) n_done++;
      if (aborted) n_abort++;
      if (done && aborted) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    waddr.delete(); wdata.delete(); vals.delete();
    n_kick = 0; n_done = 0; n_abort = 0; n_both = 0; viol = 0;
  endtask

  task automatic run_frame(input int abort_at, input int glitch_at, input bit collide,
                           output int len, output bit ok);
    int kk = 0;
    int t0 = 0;
    len = -1; ok = 1'b0;
    clear_mon();
    @(negedge clk); start = 1'b1; abort = collide;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done || aborted || err) begin len = cyc - t0; ok = 1'b1; break; end
      if (eng_start) begin
        if (kk == 0) t0 = cyc;
        abort = (kk == abort_at);
        start = (kk == glitch_at);
        kk++;
      end else begin
        abort = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("frame_end", 32'(ok), 1);
  endtask

  task automatic check_frame(input int nwr, input bit exp_done, input int exp_fc);
    chk("n_kick", n_kick, NP);
    chk("n_done", n_done, 32'(exp_done));
    chk("n_aborted", n_abort, 32'(!exp_done));
    chk("done_and_aborted", n_both, 0);
    chk("kick_while_pending", viol, 0);
    chk("n_writes", waddr.size(), nwr);
    for (int i = 0; i < nwr && i < waddr.size(); i++) begin
      chk("wr_addr", waddr[i], i);
      chk("wr_data", wdata[i], 32'(vals[i]));
    end
    chk("frame_cnt", frame_cnt, exp_fc);
    chk("busy_after", busy, 0);
    chk("err_after", err, 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, efc, kk, ndn, ab, gl;
    bit ok, found;
    efc = 0;

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, aborted, err, frame_cnt, eng_start, wr_en, wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Normal frame, nominal engine, value = 100 + pix
    run_frame(-1, -1, 1'b0, len, ok);
    efc++;
    check_frame(NP, 1'b1, efc);
    chk("frame_len", len, 300);

    // Back-to-back: start held for 3 frames
    clear_mon();
    @(negedge clk); start = 1'b1;
    kk = 0; ndn = 0;
    for (int c = 0; c < 5000; c++) begin
      if (eng_start) begin kk++; if (kk == 2 * NP + 1) start = 1'b0; end
      if (done) ndn++;
      if (ndn == 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    efc += 3;
    chk("b2b_done", n_done, 3);
    chk("b2b_kicks", n_kick, 3 * NP);
    chk("b2b_writes", waddr.size(), 3 * NP);
    chk("b2b_frame_cnt", frame_cnt, efc);
    chk("b2b_pending", viol, 0);
    for (int i = 0; i < 3 * NP && i < waddr.size(); i++) chk("b2b_addr", waddr[i], i % NP);

    // Abort during pixel 7
    run_frame(7, -1, 1'b0, len, ok);
    check_frame(7, 1'b0, efc);

    // Start+abort collision in IDLE, start pulse mid-frame
    run_frame(-1, 9, 1'b1, len, ok);
    efc++;
    check_frame(NP, 1'b1, efc);

    // Timeout: engine silent at pixel 3
    clear_mon();
    mute_pix = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    kk = 0; found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (eng_start) begin if (kk == 3) begin found = 1'b1; break; end kk++; end
      @(negedge clk);
    end
    chk("to_kick3_seen", 32'(found), 1);
    repeat (TO) @(negedge clk);
    chk("to_err_early", err, 0);
    chk("to_busy_early", busy, 1);
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_writes", waddr.size(), 3);
    chk("to_done", n_done + n_abort, 0);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_frame_cnt", frame_cnt, efc);
    mute_pix = -1;
    run_frame(-1, -1, 1'b0, len, ok);
    efc++;
    check_frame(NP, 1'b1, efc);

    // Randomized frames: random latency, data, abort point and stray starts
    fixed_lat = 0; rnd_data = 1'b1;
    for (int r = 0; r < 5; r++) begin
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NP - 2)) : -1;
      gl = int'($urandom_range(0, NP - 1));
      run_frame(ab, gl, 1'b0, len, ok);
      if (ab < 0) efc++;
      check_frame((ab < 0) ? NP : ab, ab < 0, efc);
    end

    // Reset mid-frame at pixel 12
    fixed_lat = 11; rnd_data = 1'b0;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    kk = 0; found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (eng_start) begin if (kk == 12) begin found = 1'b1; break; end kk++; end
      @(negedge clk);
    end
    chk("mid_kick12_seen", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {busy, done, aborted, err, frame_cnt, eng_start, wr_en, wr_addr, wr_data}, 0);
    @(negedge clk); rst_n = 1'b1;
    efc = 0;
    run_frame(-1, -1, 1'b0, len, ok);
    efc++;
    check_frame(NP, 1'b1, efc);
    chk("post_rst_len", len, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame-level sequencer for the single-pixel convolution engine. On a start request it triggers the engine once per output pixel, waits for each result, and writes the IMG_SIZE×IMG_SIZE results into an output buffer at linear addresses. It also supports abort with pipeline drain, a per-pixel timeout and a completed-frame counter. It sits between the system control/register block and the engine: it drives the engine's `img_valid`, consumes its `conv_out`/`conv_valid`, and drives the result-buffer write port.

## Interface
Parameters:
- DATA_WIDTH, 8, engine pixel/coefficient width; result width is 2*DATA_WIDTH
- IMG_SIZE, 5, output image side; NPIX = IMG_SIZE*IMG_SIZE pixels per frame
- TIMEOUT, 32, maximum cycles to wait for one engine result

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame request, sampled only in IDLE
- abort  in  1  abort request, sampled only while busy
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse, frame completed normally
- aborted  out  1  one-cycle pulse, aborted frame finished draining
- err  out  1  sticky timeout flag, cleared when the next start is accepted
- frame_cnt  out  8  count of normally completed frames, wraps 255→0
- eng_start  out  1  to engine `img_valid`, one-cycle pulse per pixel
- eng_valid  in  1  from engine `conv_valid` (level; engine clears it when it accepts eng_start)
- eng_data  in  2*DATA_WIDTH  from engine `conv_out`
- wr_en  out  1  result-buffer write strobe
- wr_addr  out  $clog2(NPIX)  linear address, row*IMG_SIZE+col
- wr_data  out  2*DATA_WIDTH  result value

## Operation
- All outputs are registered. Reset values: state IDLE, pix=0, drain=0, tcnt=0, and every output 0.
- IDLE: when start=1, clear err, pix, drain and tcnt, then go to KICK. abort is ignored in this state.
- KICK: eng_start=1 for this cycle only, then go to CLR.
- CLR: wait for eng_valid=0, which confirms the engine accepted the trigger, then go to WAIT.
- WAIT: wait for eng_valid=1. When it is seen:
  - Capture eng_data into wr_data and pix into wr_addr.
  - Assert wr_en for the next cycle, unless drain=1.
  - If pix==NPIX-1, go to DONE. Otherwise increment pix and go to KICK.
- DONE: one cycle.
  - If drain=0: done=1 and frame_cnt increments.
  - If drain=1: aborted=1 and frame_cnt holds.
  - Then go to IDLE.
- Timeout: tcnt counts every cycle spent in CLR or WAIT and resets on entry to KICK. When tcnt reaches TIMEOUT, set err=1 and return to IDLE immediately, with no done, no aborted and no write.
- Abort: abort=1 in any busy state sets drain=1 (sticky until the next start). The frame keeps sequencing all remaining pixels with wr_en suppressed. This is required because the engine keeps its own row/column position and can only realign by finishing the frame.
- start while busy is ignored. abort and start both high in IDLE: start wins and abort is ignored.
- Reset mid-frame returns everything to reset values. The engine must be reset by the same rst_n to stay aligned.

## Timing
- start accepted at edge E. KICK (busy=1, eng_start=1) runs during cycle E+1.
- With the nominal engine (9 CALC cycles plus 1 OUTPUT cycle), eng_valid rises 11 cycles after the KICK cycle.
- wr_en is high in the cycle after eng_valid is sampled, and that cycle coincides with the next KICK.
- Per-pixel period is 12 cycles. A 5×5 frame takes 300 cycles from KICK#0 to DONE.
- done and aborted never assert in the same cycle. busy drops in the cycle after DONE.
- wr_en is a single-cycle pulse per pixel. Addresses run 0..NPIX-1 in order, with no gaps or repeats.

## Test plan
- Normal frame: reset, then start pulse with a behavioural engine returning value = 100+pix → 25 writes to addresses 0..24 with data 100..124, done pulse, frame_cnt=1, err=0.
- Back-to-back: start held continuously for 3 frames → frame_cnt=3. Each start is accepted only in IDLE, and no eng_start occurs while a result is pending.
- Abort: assert abort during pixel 7 → writes only for addresses 0..6, eng_start still pulses 25 times, aborted=1 and done=0, frame_cnt unchanged.
- Timeout: engine stops responding at pixel 3 → err=1 exactly TIMEOUT cycles after entering CLR, busy=0, no done. The next start clears err.
- Start/abort collision and start-while-busy: both high in IDLE → frame runs normally. start pulses mid-frame → ignored, exactly 25 writes.
- Reset mid-frame (pixel 12): assert rst_n=0 → all outputs 0 immediately. A new start after release produces a normal 25-write frame from address 0.
